// File: rtl/toggle_rx_pkg.sv
// Shared constants, derived-state enum and full-count helper for the
// toggle-signalling receiver.
package toggle_rx_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_WIDTH   = 4;
  localparam int DEF_TOTAL_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FULL    = 2'd2
  } rx_state_e;

  function automatic int unsigned full_count(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam int unsigned DEF_FULL_CNT = full_count(DEF_CNT_WIDTH);

endpackage

// File: rtl/toggle_sync.sv
// Multi-flop synchroniser for a single asynchronous level.
// Clears to 0 asynchronously.
module toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic clear,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) chain <= '0;
    else       chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/toggle_event_receiver.sv
// Toggle-link receive end: sync, edge detect, pending queue, status.
// Define TOGGLE_RX_ACK_EN to build the ack_toggle return register.
module toggle_event_receiver
  import toggle_rx_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int TOTAL_WIDTH = DEF_TOTAL_WIDTH
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   toggle_in,
  output logic                   event_valid,
  input  logic                   event_ready,
  output logic [CNT_WIDTH-1:0]   pending,
  output logic [TOTAL_WIDTH-1:0] total,
  output logic                   overflow,
  output logic                   ack_toggle
);

  localparam logic [CNT_WIDTH-1:0] FULL_CNT =
    CNT_WIDTH'(full_count(CNT_WIDTH));

  logic      sync_last;
  logic      prev;
  logic      edge_det;
  logic      accept;
  logic      inc;
  logic      dec;
  rx_state_e state;

  toggle_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clock(clock),
    .clear(clear),
    .d    (toggle_in),
    .q    (sync_last)
  );

  always_comb begin
    state = IDLE;
    if (pending == FULL_CNT) state = FULL;
    else if (pending != '0)  state = PENDING;
  end

  assign event_valid = (state != IDLE);
  assign edge_det    = sync_last ^ prev;
  assign accept      = event_valid & event_ready;
  assign inc         = edge_det & ~accept;
  assign dec         = accept & ~edge_det;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      prev     <= 1'b0;
      pending  <= '0;
      total    <= '0;
      overflow <= 1'b0;
    end else begin
      prev <= sync_last;
      unique case (1'b1)
        inc: begin
          // a full queue drops the event but remembers it happened
          if (state == FULL) overflow <= 1'b1;
          else pending <= pending + CNT_WIDTH'(1);
        end
        dec:     pending <= pending - CNT_WIDTH'(1);
        default: ;
      endcase
      if (accept) total <= total + TOTAL_WIDTH'(1);
    end
  end

`ifdef TOGGLE_RX_ACK_EN
  always_ff @(posedge clock or posedge clear) begin
    if (clear)         ack_toggle <= 1'b0;
    else if (edge_det) ack_toggle <= ~ack_toggle;
  end
`else
  assign ack_toggle = 1'b0;
`endif

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Scoreboard bench for toggle_event_receiver: random and directed
// toggle traffic against an arrival-queue reference model.
module tb_toggle_event_receiver;
  import toggle_rx_pkg::*;

  localparam int CW  = DEF_CNT_WIDTH;
  localparam int TW  = DEF_TOTAL_WIDTH;
  localparam int LAT = DEF_SYNC_STAGES + 1;
  localparam int CAP = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic          toggle_in = 1'b0;
  logic          event_ready = 1'b0;
  logic          event_valid;
  logic [CW-1:0] pending;
  logic [TW-1:0] total;
  logic          overflow;
  logic          ack_toggle;

  always #5 clock = ~clock;

  toggle_event_receiver dut (
    .clock      (clock),
    .clear      (clear),
    .toggle_in  (toggle_in),
    .event_valid(event_valid),
    .event_ready(event_ready),
    .pending    (pending),
    .total      (total),
    .overflow   (overflow),
    .ack_toggle (ack_toggle)
  );

  typedef struct {
    int pend;
    int tot;
    bit ovf;
    bit ack;
  } snap_t;

  int    arr_q[$];
  snap_t exp_q[$];
  int    cyc = 0;
  int    m_pend = 0;
  int    m_tot = 0;
  bit    m_ovf = 0;
  bit    m_ack = 0;
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: events arrive LAT edges after the toggle is driven
  always @(posedge clock) begin
    snap_t s;
    bit ev;
    bit acc;
    cyc++;
    if (clear) begin
      arr_q.delete();
      m_pend = 0;
      m_tot  = 0;
      m_ovf  = 0;
      m_ack  = 0;
    end else begin
      ev  = (arr_q.size() != 0) && (arr_q[0] == cyc);
      acc = (m_pend > 0) && (event_ready === 1'b1);
      if (ev) void'(arr_q.pop_front());
      if (ev) m_ack = !m_ack;
      if (acc) m_tot = (m_tot + 1) % (1 << TW);
      if (ev && !acc) begin
        if (m_pend == CAP) m_ovf = 1;
        else m_pend++;
      end else if (acc && !ev) begin
        m_pend--;
      end
    end
    s.pend = m_pend;
    s.tot  = m_tot;
    s.ovf  = m_ovf;
    s.ack  = m_ack;
    exp_q.push_back(s);
  end

  always @(posedge clock) begin
    snap_t s;
    bit    eack;
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      s = exp_q.pop_front();
`ifdef TOGGLE_RX_ACK_EN
      eack = s.ack;
`else
      eack = 1'b0;
`endif
      chk("pending", 32'(pending), 32'(s.pend));
      chk("total", 32'(total), 32'(s.tot));
      chk("overflow", 32'(overflow), 32'(s.ovf));
      chk("event_valid", 32'(event_valid), 32'(s.pend != 0));
      chk("ack_toggle", 32'(ack_toggle), 32'(eack));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send();
    toggle_in = ~toggle_in;
    arr_q.push_back(cyc + LAT);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_pending"}, 32'(pending), 32'd0);
    chk({tag, "_total"}, 32'(total), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_valid"}, 32'(event_valid), 32'd0);
    chk({tag, "_ack"}, 32'(ack_toggle), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    toggle_in = 1'b0;
    event_ready = 1'b0;
    #1;
    zero_chk("clear_async");
    step(2);
    clear = 1'b0;
    step(2);
  endtask

  initial begin
    #1;
    zero_chk("reset");
    step(3);
    clear = 1'b0;
    step(2);

    // single event, then one accept
    send();
    step(4);
    event_ready = 1'b1;
    step(1);
    event_ready = 1'b0;
    step(2);

    // five events, then drain
    repeat (5) begin
      send();
      step(3);
    end
    step(3);
    event_ready = 1'b1;
    step(7);
    event_ready = 1'b0;

    // arrival coincides with an accept at pending=2
    send();
    step(3);
    send();
    step(4);
    send();
    step(2);
    event_ready = 1'b1;
    step(1);
    event_ready = 1'b0;
    step(3);

    // overflow, one accept, drain to 3, then clear mid-run
    do_clear();
    repeat (16) begin
      send();
      step(3);
    end
    step(3);
    event_ready = 1'b1;
    step(1);
    event_ready = 1'b0;
    step(2);
    event_ready = 1'b1;
    step(11);
    event_ready = 1'b0;
    step(1);
    do_clear();

    // random traffic; enough accepts to wrap total
    for (int i = 0; i < 320; i++) begin
      send();
      repeat ($urandom_range(3, 6)) begin
        event_ready = ($urandom_range(0, 3) != 0);
        step(1);
      end
    end
    event_ready = 1'b1;
    step(24);
    event_ready = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
